// File: rtl/genius_pkg.sv
// Shared types for the Genius game blocks: LED/button color codes and the
// color_display FSM state, plus small helpers used by color_display.
package genius_pkg;

  // Color code shared with the player button decoder.
  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    RED    = 2'b01,
    BLUE   = 2'b10,
    YELLOW = 2'b11
  } color_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    GAP  = 2'b10
  } disp_state_t;

  // LED vector bit order: {yellow, blue, red, green}.
  localparam logic [3:0] LedsOff = 4'b0000;
  localparam logic [3:0] LedsAll = 4'b1111;

  function automatic logic [3:0] color_to_leds(input color_t color);
    logic [3:0] leds;
    leds = LedsOff;
    unique case (color)
      GREEN:  leds = 4'b0001;
      RED:    leds = 4'b0010;
      BLUE:   leds = 4'b0100;
      YELLOW: leds = 4'b1000;
      default: leds = LedsOff;
    endcase
    return leds;
  endfunction

  // Counter must hold max(on, off) - 1; sized as $clog2(max + 1).
  function automatic int unsigned cnt_width(input int unsigned on_cycles,
                                            input int unsigned off_cycles);
    int unsigned max_cycles;
    max_cycles = (on_cycles > off_cycles) ? on_cycles : off_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/color_display_if.sv
// Valid/ready color-code channel from the sequence controller to color_display.
interface color_display_if;

  logic [1:0] color_in;
  logic       color_valid;
  logic       color_ready;

  modport master (
    output color_in,
    output color_valid,
    input  color_ready
  );

  modport slave (
    input  color_in,
    input  color_valid,
    output color_ready
  );

endinterface

// File: rtl/dwell_timer.sv
// Loadable down-counter used for both the lit and the dark periods.
// Loads on i_load, otherwise counts down and holds at zero (no wrap).
module dwell_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_value,
  output logic             o_zero
);

  logic [Width-1:0] r_count;

  // Count register: reload on state entry, else decrement down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - Width'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/color_display.sv
// color_display: shows one color code at a time on four LEDs -- lit for
// ON_CYCLES, dark for OFF_CYCLES, then a one-cycle done pulse.
// Optional feature macro COLOR_DISPLAY_FLASH_ALL_EN adds a flash_all input
// that lights all four LEDs for one display period from IDLE.
module color_display
  import genius_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 25_000_000,
  parameter int unsigned OFF_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  color_display_if.slave bus,
`ifdef COLOR_DISPLAY_FLASH_ALL_EN
  input  logic flash_all,
`endif
  output logic led_green,
  output logic led_red,
  output logic led_blue,
  output logic led_yellow,
  output logic busy,
  output logic done
);

  localparam int unsigned CntW = cnt_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [CntW-1:0] OnLoad  = CntW'(ON_CYCLES - 1);
  localparam logic [CntW-1:0] OffLoad = CntW'((OFF_CYCLES == 0) ? 0 : OFF_CYCLES - 1);

  disp_state_t     r_state, w_state_d;
  color_t          r_color, w_color_d;
  logic            r_flash, w_flash_d;
  logic [3:0]      r_leds, w_leds_d;
  logic            r_done, w_done_d;
  logic            w_ready;
  logic            w_flash_req;
  logic            w_load;
  logic [CntW-1:0] w_load_value;
  logic            w_zero;

`ifdef COLOR_DISPLAY_FLASH_ALL_EN
  assign w_flash_req = flash_all;
`else
  assign w_flash_req = 1'b0;
`endif

  dwell_timer #(
    .Width (CntW)
  ) u_dwell_timer (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .o_zero       (w_zero)
  );

  // Next-state, latch, LED decode and counter-load control.
  always_comb begin
    w_state_d    = r_state;
    w_color_d    = r_color;
    w_flash_d    = r_flash;
    w_leds_d     = LedsOff;
    w_done_d     = 1'b0;
    w_ready      = 1'b0;
    w_load       = 1'b0;
    w_load_value = OnLoad;

    unique case (r_state)
      IDLE: begin
        // flash_all wins over a simultaneous code, and blocks the handshake.
        w_ready = !rst && !w_flash_req;
        if (w_flash_req) begin
          w_flash_d = 1'b1;
          w_state_d = ON;
          w_load    = 1'b1;
          w_leds_d  = LedsAll;
        end else if (bus.color_valid && w_ready) begin
          w_color_d = color_t'(bus.color_in);
          w_flash_d = 1'b0;
          w_state_d = ON;
          w_load    = 1'b1;
          w_leds_d  = color_to_leds(color_t'(bus.color_in));
        end
      end
      ON: begin
        w_leds_d = r_flash ? LedsAll : color_to_leds(r_color);
        if (w_zero) begin
          w_leds_d = LedsOff;
          if (OFF_CYCLES > 0) begin
            w_state_d    = GAP;
            w_load       = 1'b1;
            w_load_value = OffLoad;
          end else begin
            w_state_d = IDLE;
            w_done_d  = 1'b1;
          end
        end
      end
      GAP: begin
        if (w_zero) begin
          w_state_d = IDLE;
          w_done_d  = 1'b1;
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  // State, latched color and registered LED/done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_color <= GREEN;
      r_flash <= 1'b0;
      r_leds  <= LedsOff;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_color <= w_color_d;
      r_flash <= w_flash_d;
      r_leds  <= w_leds_d;
      r_done  <= w_done_d;
    end
  end

  assign bus.color_ready = w_ready;
  assign led_green       = r_leds[0];
  assign led_red         = r_leds[1];
  assign led_blue        = r_leds[2];
  assign led_yellow      = r_leds[3];
  assign busy            = (r_state != IDLE);
  assign done            = r_done;

endmodule

// File: tb/tb_color_display.sv
// Directed bench for color_display: DUT A uses ON=4/OFF=2, DUT B ON=4/OFF=0.
module tb_color_display;

  logic clk;
  logic rst;

  color_display_if bus_a ();
  color_display_if bus_b ();

  logic flash_a;
  logic flash_b;
  logic g_a, r_a, b_a, y_a, busy_a, done_a;
  logic g_b, r_b, b_b, y_b, busy_b, done_b;
  logic [3:0] leds_a, leds_b;

  assign leds_a = {y_a, b_a, r_a, g_a};
  assign leds_b = {y_b, b_b, r_b, g_b};

  color_display #(
    .ON_CYCLES  (4),
    .OFF_CYCLES (2)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_a),
`ifdef COLOR_DISPLAY_FLASH_ALL_EN
    .flash_all  (flash_a),
`endif
    .led_green  (g_a),
    .led_red    (r_a),
    .led_blue   (b_a),
    .led_yellow (y_a),
    .busy       (busy_a),
    .done       (done_a)
  );

  color_display #(
    .ON_CYCLES  (4),
    .OFF_CYCLES (0)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_b),
`ifdef COLOR_DISPLAY_FLASH_ALL_EN
    .flash_all  (flash_b),
`endif
    .led_green  (g_b),
    .led_red    (r_b),
    .led_blue   (b_b),
    .led_yellow (y_b),
    .busy       (busy_b),
    .done       (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] codes [3];
  logic [3:0] pats  [3];

  initial begin
    codes = '{2'b00, 2'b01, 2'b11};
    pats  = '{4'b0001, 4'b0010, 4'b1000};

    rst               = 1'b1;
    flash_a           = 1'b0;
    flash_b           = 1'b0;
    bus_a.color_in    = 2'b00;
    bus_a.color_valid = 1'b0;
    bus_b.color_in    = 2'b00;
    bus_b.color_valid = 1'b0;

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_leds", leds_a, 4'b0000);
      check("rst_busy", busy_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_ready", bus_a.color_ready, 1'b0);
    end
    rst = 1'b0;
    #1;
    check("rel_ready_a", bus_a.color_ready, 1'b1);
    check("rel_ready_b", bus_b.color_ready, 1'b1);

    // Single blue display.
    bus_a.color_in    = 2'b10;
    bus_a.color_valid = 1'b1;
    tick();
    bus_a.color_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("blue_lit", leds_a, 4'b0100);
      check("blue_busy", busy_a, 1'b1);
      check("blue_ready", bus_a.color_ready, 1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      check("blue_gap", leds_a, 4'b0000);
      check("blue_gap_busy", busy_a, 1'b1);
      check("blue_gap_done", done_a, 1'b0);
      tick();
    end
    check("blue_done", done_a, 1'b1);
    check("blue_done_ready", bus_a.color_ready, 1'b1);
    check("blue_done_busy", busy_a, 1'b0);
    check("blue_done_leds", leds_a, 4'b0000);
    tick();
    check("blue_done_pulse", done_a, 1'b0);

    // Valid held continuously; codes changed while busy must be dropped.
    bus_a.color_valid = 1'b1;
    bus_a.color_in    = codes[0];
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k < 2) bus_a.color_in = codes[k+1];
      else bus_a.color_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("seq%0d_lit", k), leds_a, pats[k]);
        check($sformatf("seq%0d_ready", k), bus_a.color_ready, 1'b0);
        tick();
      end
      for (int i = 0; i < 2; i++) begin
        check($sformatf("seq%0d_gap", k), leds_a, 4'b0000);
        tick();
      end
      check($sformatf("seq%0d_done", k), done_a, 1'b1);
      check($sformatf("seq%0d_done_ready", k), bus_a.color_ready, 1'b1);
    end
    tick();
    check("seq_idle_leds", leds_a, 4'b0000);
    check("seq_idle_done", done_a, 1'b0);

    // Reset on the second lit cycle of red.
    bus_a.color_in    = 2'b01;
    bus_a.color_valid = 1'b1;
    tick();
    bus_a.color_valid = 1'b0;
    check("red_lit1", leds_a, 4'b0010);
    tick();
    check("red_lit2", leds_a, 4'b0010);
    rst = 1'b1;
    tick();
    check("midrst_leds", leds_a, 4'b0000);
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_done", done_a, 1'b0);
    check("midrst_ready", bus_a.color_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_rel_ready", bus_a.color_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check("midrst_no_done", done_a, 1'b0);
      check("midrst_dark", leds_a, 4'b0000);
      tick();
    end

    // OFF_CYCLES=0: yellow then done immediately, then a back-to-back green.
    bus_b.color_in    = 2'b11;
    bus_b.color_valid = 1'b1;
    tick();
    bus_b.color_in = 2'b00;
    for (int i = 0; i < 4; i++) begin
      check("b_yel_lit", leds_b, 4'b1000);
      check("b_yel_ready", bus_b.color_ready, 1'b0);
      tick();
    end
    check("b_yel_done", done_b, 1'b1);
    check("b_yel_done_ready", bus_b.color_ready, 1'b1);
    check("b_yel_done_leds", leds_b, 4'b0000);
    check("b_yel_done_busy", busy_b, 1'b0);
    tick();
    bus_b.color_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b_grn_lit", leds_b, 4'b0001);
      check("b_grn_busy", busy_b, 1'b1);
      tick();
    end
    check("b_grn_done", done_b, 1'b1);
    tick();
    check("b_grn_done_pulse", done_b, 1'b0);

`ifdef COLOR_DISPLAY_FLASH_ALL_EN
    // flash_all beats a simultaneous red request.
    flash_a           = 1'b1;
    bus_a.color_in    = 2'b01;
    bus_a.color_valid = 1'b1;
    #1;
    check("flash_ready", bus_a.color_ready, 1'b0);
    tick();
    flash_a           = 1'b0;
    bus_a.color_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("flash_lit", leds_a, 4'b1111);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      check("flash_gap", leds_a, 4'b0000);
      tick();
    end
    check("flash_done", done_a, 1'b1);
    tick();
    check("flash_no_red", leds_a, 4'b0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
